fetch_ctrl: RTL and testbench

Fetch-stage sequencer. It owns the program counter and issues one instruction-memory request at a time over a req/ack plus rvalid handshake. Returned instructions are buffered, tagged with their PC, in a small FIFO that feeds decode under valid/ready. It sits between the PC/next-PC datapath and decode, and takes taken-branch/jump redirects from execute, which flush all wrong-path state.

---
 rtl/fetch_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer.
// Owns the PC and issues one instruction-memory request at a time.
// Returned words are tagged with their PC and queued toward decode.
// Execute redirects flush all wrong-path state: queued entries, the
// pending request, and any response still in flight.
module fetch_ctrl #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = {DATA_WIDTH{1'b0}},
  parameter int                    QUEUE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] pc
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  req_q, req_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] ins_mem_q [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] ins_mem_d [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] pcm_mem_q [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] pcm_mem_d [QUEUE_DEPTH];

  logic                  ack_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  valid_s;
  logic [DATA_WIDTH-1:0] target_s;

  // Handshake qualification: the ack only counts while a request is shown,
  // and a redirect hides the head so decode cannot consume wrong-path work.
  always_comb begin
    ack_s    = req_q & imem_ack;
    valid_s  = (count_q != {CNT_W{1'b0}}) & ~redirect_valid;
    pop_s    = valid_s & instr_ready;
    push_s   = (state_q == S_WAIT) & imem_rvalid & ~redirect_valid;
    target_s = {redirect_target[DATA_WIDTH-1:2], 2'b00};
  end

  // Instruction FIFO: push at tail, pop at head, flush on redirect.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    ins_mem_d = ins_mem_q;
    pcm_mem_d = pcm_mem_q;
    if (redirect_valid) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        ins_mem_d[tail_q] = imem_rdata;
        pcm_mem_d[tail_q] = req_pc_q;
        tail_d            = tail_q + PTR_W'(1);
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = head_q + PTR_W'(1);
      end else begin
        head_d = head_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Fetch FSM next state and PC; a redirect overrides every other transition.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (redirect_valid) begin
      pc_d = target_s;
      case (state_q)
        S_REQ:   state_d = ack_s ? S_DROP : S_REQ;
        S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state_d = imem_rvalid ? S_REQ : S_DROP;
        S_HOLD:  state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          // Never issue without a free slot reserved for the response.
          if (count_q >= DEPTH_C) begin
            state_d = S_HOLD;
          end else if (ack_s) begin
            pc_d     = pc_q + DATA_WIDTH'(4);
            req_pc_d = pc_q;
            state_d  = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_d = (count_d < DEPTH_C) ? S_REQ : S_HOLD;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_HOLD:  state_d = (count_d < DEPTH_C) ? S_REQ : S_HOLD;
        S_DROP:  state_d = imem_rvalid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end
  end

  // Registered request strobe: asserted whenever the next state issues.
  always_comb begin
    req_d = (state_d == S_REQ) && (count_d < DEPTH_C);
  end

  // State registers with synchronous reset; the FIFO storage is cleared so the
  // head outputs read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      req_q    <= 1'b0;
      head_q   <= {PTR_W{1'b0}};
      tail_q   <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        ins_mem_q[i] <= {DATA_WIDTH{1'b0}};
        pcm_mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      req_q     <= req_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ins_mem_q <= ins_mem_d;
      pcm_mem_q <= pcm_mem_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = valid_s;
  assign instr       = ins_mem_q[head_q];
  assign instr_pc    = pcm_mem_q[head_q];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small latency-programmable memory.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b1;
  logic [31:0] pc;

  int n_tests = 0;
  int n_fail  = 0;

  // memory model: ack immediately, respond lat cycles after the ack cycle
  int          lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;

  // decode-side log and request counter
  int          log_n = 0;
  logic [31:0] log_pc    [64];
  logic [31:0] log_instr [64];
  int          ack_n = 0;

  fetch_ctrl #(.DATA_WIDTH(32), .RESET_PC(32'h0), .QUEUE_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .pc(pc)
  );

  always #5 clk = ~clk;

  assign imem_ack    = imem_req;
  assign imem_rvalid = pend && (cnt == 0);
  assign imem_rdata  = 32'hA000_0000 | paddr;

  // memory response pipeline
  always @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
    end else begin
      if (imem_rvalid) pend <= 1'b0;
      else if (pend) cnt <= cnt - 1;
      if (imem_req && imem_ack) begin
        pend  <= 1'b1;
        cnt   <= lat - 1;
        paddr <= imem_addr;
      end
    end
  end

  // record every decode handshake and every accepted request
  always @(posedge clk) begin
    if (!rst && instr_valid && instr_ready && log_n < 64) begin
      log_pc[log_n]    <= instr_pc;
      log_instr[log_n] <= instr;
      log_n            <= log_n + 1;
    end
    if (!rst && imem_req && imem_ack) ack_n <= ack_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   {31'h0, imem_req},    32'h0);
    check({tag, "_addr"},  imem_addr,            32'h0);
    check({tag, "_pc"},    pc,                   32'h0);
    check({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
    check({tag, "_instr"}, instr,                32'h0);
    check({tag, "_ipc"},   instr_pc,             32'h0);
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int base_ack;
  int base_log;

  initial begin
    // ---- reset then stream ----
    rst = 1'b1; instr_ready = 1'b1; lat = 1;
    tick(); tick();
    check_reset_vals("rst_hold");
    rst = 1'b0; #1;
    check("c0_req",   {31'h0, imem_req},    32'h0);
    check("c0_valid", {31'h0, instr_valid}, 32'h0);
    tick();  // c1
    check("s_c1_req",  {31'h0, imem_req}, 32'h1);
    check("s_c1_addr", imem_addr,         32'h0);
    tick();  // c2
    check("s_c2_req",   {31'h0, imem_req},    32'h0);
    check("s_c2_pc",    pc,                   32'h4);
    check("s_c2_valid", {31'h0, instr_valid}, 32'h0);
    tick();  // c3
    check("s_c3_valid", {31'h0, instr_valid}, 32'h1);
    check("s_c3_ipc",   instr_pc,             32'h0);
    check("s_c3_instr", instr,                32'hA000_0000);
    check("s_c3_addr",  imem_addr,            32'h4);
    tick(); tick();  // c5
    check("s_c5_ipc", instr_pc, 32'h4);
    tick(); tick();  // c7
    check("s_c7_ipc",   instr_pc, 32'h8);
    check("s_c7_instr", instr,    32'hA000_0008);
    tick();  // c8
    check("s_log_n",   log_n,        32'd3);
    check("s_log_pc0", log_pc[0],    32'h0);
    check("s_log_pc1", log_pc[1],    32'h4);
    check("s_log_pc2", log_pc[2],    32'h8);
    check("s_log_in2", log_instr[2], 32'hA000_0008);

    // ---- backpressure ----
    instr_ready = 1'b0;
    do_reset();
    base_ack = ack_n;
    tick(); tick(); tick(); tick(); tick();  // c5
    check("bp_c5_req",   {31'h0, imem_req},    32'h0);
    check("bp_c5_valid", {31'h0, instr_valid}, 32'h1);
    check("bp_c5_ipc",   instr_pc,             32'h0);
    check("bp_c5_instr", instr,                32'hA000_0000);
    check("bp_c5_acks",  ack_n - base_ack,     32'd2);
    tick();  // c6
    check("bp_c6_req", {31'h0, imem_req}, 32'h0);
    check("bp_c6_ipc", instr_pc,          32'h0);
    instr_ready = 1'b1;
    tick();  // c7
    instr_ready = 1'b0;
    check("bp_c7_req",  {31'h0, imem_req}, 32'h1);
    check("bp_c7_addr", imem_addr,         32'h8);
    check("bp_c7_ipc",  instr_pc,          32'h4);
    tick(); tick();  // c9
    check("bp_c9_req",  {31'h0, imem_req}, 32'h0);
    check("bp_c9_acks", ack_n - base_ack,  32'd3);
    tick();  // c10
    check("bp_c10_req", {31'h0, imem_req}, 32'h0);
    check("bp_c10_ipc", instr_pc,          32'h4);

    // ---- redirect during WAIT with late response ----
    instr_ready = 1'b1; lat = 3;
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'h10;
    base_log = log_n;
    tick();  // c1
    redirect_valid = 1'b0;
    check("rw_c1_req",  {31'h0, imem_req}, 32'h1);
    check("rw_c1_addr", imem_addr,         32'h10);
    tick();  // c2
    check("rw_c2_req", {31'h0, imem_req}, 32'h0);
    check("rw_c2_pc",  pc,                32'h14);
    redirect_valid = 1'b1; redirect_target = 32'h103;
    tick();  // c3
    redirect_valid = 1'b0;
    check("rw_c3_req", {31'h0, imem_req}, 32'h0);
    check("rw_c3_pc",  pc,                32'h100);
    tick();  // c4: late response arrives and is dropped
    check("rw_c4_valid", {31'h0, instr_valid}, 32'h0);
    check("rw_c4_req",   {31'h0, imem_req},    32'h0);
    lat = 1;
    tick();  // c5
    check("rw_c5_req",   {31'h0, imem_req},    32'h1);
    check("rw_c5_addr",  imem_addr,            32'h100);
    check("rw_c5_valid", {31'h0, instr_valid}, 32'h0);
    tick();  // c6
    check("rw_c6_valid", {31'h0, instr_valid}, 32'h0);
    tick();  // c7
    check("rw_c7_valid", {31'h0, instr_valid}, 32'h1);
    check("rw_c7_ipc",   instr_pc,             32'h100);
    check("rw_c7_instr", instr,                32'hA000_0100);
    check("rw_c7_log",   log_n - base_log,     32'd0);
    tick();  // c8
    check("rw_c8_log",   log_n - base_log,     32'd1);
    check("rw_c8_logpc", log_pc[base_log],     32'h100);

    // ---- redirect coincident with ack ----
    do_reset();
    base_ack = ack_n; base_log = log_n;
    tick();  // c1
    check("ra_c1_req", {31'h0, imem_req}, 32'h1);
    redirect_valid = 1'b1; redirect_target = 32'h200;
    tick();  // c2 (DROP, response arrives)
    redirect_valid = 1'b0;
    check("ra_c2_req",   {31'h0, imem_req},    32'h0);
    check("ra_c2_pc",    pc,                   32'h200);
    check("ra_c2_valid", {31'h0, instr_valid}, 32'h0);
    tick();  // c3
    check("ra_c3_req",   {31'h0, imem_req},    32'h1);
    check("ra_c3_addr",  imem_addr,            32'h200);
    check("ra_c3_valid", {31'h0, instr_valid}, 32'h0);
    tick();  // c4
    check("ra_c4_valid", {31'h0, instr_valid}, 32'h0);
    tick();  // c5
    check("ra_c5_valid", {31'h0, instr_valid}, 32'h1);
    check("ra_c5_ipc",   instr_pc,             32'h200);
    check("ra_c5_acks",  ack_n - base_ack,     32'd2);
    check("ra_c5_log",   log_n - base_log,     32'd0);

    // ---- redirect coincident with rvalid ----
    do_reset();
    tick();  // c1
    tick();  // c2
    redirect_valid = 1'b1; redirect_target = 32'h302;
    tick();  // c3
    redirect_valid = 1'b0;
    check("rv_c3_req",   {31'h0, imem_req},    32'h1);
    check("rv_c3_addr",  imem_addr,            32'h300);
    check("rv_c3_valid", {31'h0, instr_valid}, 32'h0);
    tick();  // c4
    check("rv_c4_valid", {31'h0, instr_valid}, 32'h0);
    tick();  // c5
    check("rv_c5_valid", {31'h0, instr_valid}, 32'h1);
    check("rv_c5_ipc",   instr_pc,             32'h300);
    check("rv_c5_instr", instr,                32'hA000_0300);

    // ---- redirect with FIFO full and decode ready ----
    instr_ready = 1'b0;
    do_reset();
    tick(); tick(); tick(); tick(); tick();  // c5
    check("rf_c5_full", {31'h0, instr_valid}, 32'h1);
    instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'h400;
    base_log = log_n;
    #1;
    check("rf_c5_valid", {31'h0, instr_valid}, 32'h0);
    tick();  // c6
    redirect_valid = 1'b0;
    check("rf_c6_log",   log_n - base_log,     32'd0);
    check("rf_c6_req",   {31'h0, imem_req},    32'h1);
    check("rf_c6_addr",  imem_addr,            32'h400);
    check("rf_c6_valid", {31'h0, instr_valid}, 32'h0);
    tick(); tick();  // c8
    check("rf_c8_valid", {31'h0, instr_valid}, 32'h1);
    check("rf_c8_ipc",   instr_pc,             32'h400);
    tick();  // c9
    check("rf_c9_log",   log_n - base_log,     32'd1);
    check("rf_c9_logpc", log_pc[base_log],     32'h400);

    // ---- reset mid-WAIT ----
    instr_ready = 1'b1; lat = 3;
    do_reset();
    tick();  // c1
    tick();  // c2
    check("rm_c2_req", {31'h0, imem_req}, 32'h0);
    rst = 1'b1;
    tick();  // c3
    check_reset_vals("rm_rst");
    rst = 1'b0; lat = 1;
    tick();  // c4
    check("rm_c4_req",  {31'h0, imem_req}, 32'h1);
    check("rm_c4_addr", imem_addr,         32'h0);
    tick();  // c5
    check("rm_c5_pc", pc, 32'h4);
    tick();  // c6
    check("rm_c6_valid", {31'h0, instr_valid}, 32'h1);
    check("rm_c6_ipc",   instr_pc,             32'h0);
    check("rm_c6_instr", instr,                32'hA000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
